// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings, command opcodes, driver FSM states and
// the IEEE 1149.1 TAP next-state function.
package jtag_pkg;

  localparam logic [3:0] TapTestLogicReset = 4'd0;
  localparam logic [3:0] TapRunTestIdle    = 4'd1;
  localparam logic [3:0] TapSelectDrScan   = 4'd2;
  localparam logic [3:0] TapCaptureDr      = 4'd3;
  localparam logic [3:0] TapShiftDr        = 4'd4;
  localparam logic [3:0] TapExit1Dr        = 4'd5;
  localparam logic [3:0] TapPauseDr        = 4'd6;
  localparam logic [3:0] TapExit2Dr        = 4'd7;
  localparam logic [3:0] TapUpdateDr       = 4'd8;
  localparam logic [3:0] TapSelectIrScan   = 4'd9;
  localparam logic [3:0] TapCaptureIr      = 4'd10;
  localparam logic [3:0] TapShiftIr        = 4'd11;
  localparam logic [3:0] TapExit1Ir        = 4'd12;
  localparam logic [3:0] TapPauseIr        = 4'd13;
  localparam logic [3:0] TapExit2Ir        = 4'd14;
  localparam logic [3:0] TapUpdateIr       = 4'd15;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  typedef logic [2:0] drv_state_t;
  localparam drv_state_t StInit    = 3'd0;
  localparam drv_state_t StReady   = 3'd1;
  localparam drv_state_t StPathIn  = 3'd2;
  localparam drv_state_t StShift   = 3'd3;
  localparam drv_state_t StPathOut = 3'd4;
  localparam drv_state_t StDone    = 3'd5;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    logic [3:0] n;
    case (s)
      TapTestLogicReset: n = tms ? TapTestLogicReset : TapRunTestIdle;
      TapRunTestIdle:    n = tms ? TapSelectDrScan   : TapRunTestIdle;
      TapSelectDrScan:   n = tms ? TapSelectIrScan   : TapCaptureDr;
      TapCaptureDr:      n = tms ? TapExit1Dr        : TapShiftDr;
      TapShiftDr:        n = tms ? TapExit1Dr        : TapShiftDr;
      TapExit1Dr:        n = tms ? TapUpdateDr       : TapPauseDr;
      TapPauseDr:        n = tms ? TapExit2Dr        : TapPauseDr;
      TapExit2Dr:        n = tms ? TapUpdateDr       : TapShiftDr;
      TapUpdateDr:       n = tms ? TapSelectDrScan   : TapRunTestIdle;
      TapSelectIrScan:   n = tms ? TapTestLogicReset : TapCaptureIr;
      TapCaptureIr:      n = tms ? TapExit1Ir        : TapShiftIr;
      TapShiftIr:        n = tms ? TapExit1Ir        : TapShiftIr;
      TapExit1Ir:        n = tms ? TapUpdateIr       : TapPauseIr;
      TapPauseIr:        n = tms ? TapExit2Ir        : TapPauseIr;
      TapExit2Ir:        n = tms ? TapUpdateIr       : TapShiftIr;
      default:           n = tms ? TapSelectDrScan   : TapRunTestIdle;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_shifter.sv
// TDI shift-out / TDO shift-in register with bit index. The *_next outputs describe the bit
// that will be current after this edge, so the driver can register TDI/TMS without lag.
module jtag_shifter #(
  parameter int unsigned MAXLEN = 32,
  parameter int unsigned LENW   = $clog2(MAXLEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [LENW-1:0]   load_len_i,
  input  logic [MAXLEN-1:0] load_data_i,
  input  logic              shift_i,
  input  logic              tdo_i,
  output logic              last_o,
  output logic              tdi_next_o,
  output logic              last_next_o,
  output logic [MAXLEN-1:0] captured_o
);

  logic [MAXLEN-1:0] data_q, data_d, cap_q, cap_d;
  logic [LENW-1:0]   idx_q, idx_d, len_q, len_d;

  always_comb begin
    data_d = data_q;
    cap_d  = cap_q;
    idx_d  = idx_q;
    len_d  = len_q;
    if (load_i) begin
      data_d = load_data_i;
      cap_d  = '0;
      idx_d  = '0;
      len_d  = load_len_i;
    end else if (shift_i) begin
      for (int unsigned i = 0; i < MAXLEN; i++) begin
        if (idx_q == LENW'(i)) cap_d[i] = tdo_i;
      end
      data_d = data_q >> 1;
      idx_d  = idx_q + LENW'(1);
    end
  end

  assign last_o      = (idx_q == len_q - LENW'(1));
  assign tdi_next_o  = data_d[0];
  assign last_next_o = (idx_d == len_d - LENW'(1));
  assign captured_o  = cap_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
      cap_q  <= '0;
      idx_q  <= '0;
      len_q  <= '0;
    end else begin
      data_q <= data_d;
      cap_q  <= cap_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
    end
  end

endmodule

// File: rtl/jtag_tap_driver.sv
// Host-side JTAG master: walks the target TAP with registered TMS/TDI and captures TDO.
// Optional macro TAP_MIRROR_EN adds a tap_state output tracking the target TAP state.
module jtag_tap_driver
  import jtag_pkg::*;
#(
  parameter int unsigned MAXLEN = 32,
  parameter int unsigned LENW   = $clog2(MAXLEN + 1)
) (
  input  logic              TCK,
  input  logic              TRST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LENW-1:0]   cmd_len,
  input  logic [MAXLEN-1:0] cmd_data,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO,
  output logic              rsp_valid,
  output logic [MAXLEN-1:0] rsp_data
`ifdef TAP_MIRROR_EN
  ,
  output logic [3:0]        tap_state
`endif
);

  localparam int unsigned CntW = (LENW > 3) ? LENW : 3;

  drv_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      pat_q, pat_d;
  logic [1:0]      op_q, op_d;
  logic            empty_q, empty_d;
  logic            tms_q, tms_d, tdi_q, tdi_d, rsp_valid_q;
  logic            load, shift, last_cur, tdi_next, last_next;
  logic [LENW-1:0] nlen;

  assign nlen = (cmd_len > LENW'(MAXLEN)) ? LENW'(MAXLEN) : cmd_len;

  jtag_shifter #(
    .MAXLEN (MAXLEN),
    .LENW   (LENW)
  ) u_shifter (
    .clk_i       (TCK),
    .rst_ni      (TRST_N),
    .load_i      (load),
    .load_len_i  (nlen),
    .load_data_i (cmd_data),
    .shift_i     (shift),
    .tdo_i       (TDO),
    .last_o      (last_cur),
    .tdi_next_o  (tdi_next),
    .last_next_o (last_next),
    .captured_o  (rsp_data)
  );

  // Each branch sets the TMS/TDI value for the cycle that follows this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    op_d    = op_q;
    empty_d = empty_q;
    tms_d   = 1'b0;
    tdi_d   = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StInit: begin
        tms_d = (cnt_q < CntW'(5));
        if (cnt_q == CntW'(6)) state_d = StReady;
        else                   cnt_d   = cnt_q + CntW'(1);
      end
      StReady: begin
        if (cmd_valid) begin
          load    = 1'b1;
          op_d    = cmd_op;
          empty_d = (nlen == '0);
          state_d = StPathIn;
          // Path patterns are LSB-first; a zero length exits Capture straight to Exit1.
          unique case (cmd_op)
            OP_RESET: begin pat_d = 6'b011111; cnt_d = CntW'(6); end
            OP_IR:    begin pat_d = empty_d ? 6'b001011 : 6'b000011; cnt_d = CntW'(4); end
            OP_DR:    begin pat_d = empty_d ? 6'b000101 : 6'b000001; cnt_d = CntW'(3); end
            OP_IDLE:  begin pat_d = 6'b000000; cnt_d = empty_d ? CntW'(1) : CntW'(nlen); end
          endcase
          tms_d = pat_d[0];
        end
      end
      StPathIn: begin
        if (cnt_q > CntW'(1)) begin
          cnt_d = cnt_q - CntW'(1);
          pat_d = pat_q >> 1;
          tms_d = pat_d[0];
        end else if (op_q == OP_RESET || op_q == OP_IDLE) begin
          state_d = StDone;
        end else if (empty_q) begin
          state_d = StPathOut;
          cnt_d   = CntW'(2);
          tms_d   = 1'b1;
        end else begin
          state_d = StShift;
          tms_d   = last_next;
          tdi_d   = tdi_next;
        end
      end
      StShift: begin
        shift = 1'b1;
        if (last_cur) begin
          state_d = StPathOut;
          cnt_d   = CntW'(2);
          tms_d   = 1'b1;
        end else begin
          tms_d = last_next;
          tdi_d = tdi_next;
        end
      end
      StPathOut: begin
        if (cnt_q > CntW'(1)) cnt_d   = cnt_q - CntW'(1);
        else                  state_d = StDone;
      end
      StDone:  state_d = StReady;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      pat_q       <= '0;
      op_q        <= OP_RESET;
      empty_q     <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      op_q        <= op_d;
      empty_q     <= empty_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= (state_d == StDone);
    end
  end

  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign cmd_ready = (state_q == StReady);

`ifdef TAP_MIRROR_EN
  logic [3:0] tap_q;

  // Advances on the same edge at which the target samples the registered TMS.
  always_ff @(posedge TCK) begin
    if (!TRST_N) tap_q <= TapTestLogicReset;
    else         tap_q <= tap_next(tap_q, tms_q);
  end

  assign tap_state = tap_q;
`endif

endmodule
